// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and slice width for the wide-add sequencer.
`default_nettype none

package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wide_add_sequencer_if.sv
// wide_add_sequencer_if: start/busy/done handshake plus operand and result buses.
`default_nettype none

interface wide_add_sequencer_if #(
  parameter int NIBBLES = 4
);

  localparam int W = adder_pkg::NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/carrylookadder.sv
// carrylookadder: 4-bit carry-lookahead adder slice.
`default_nettype none

module carrylookadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_bit
      assign g[i] = a[i] & b[i];
      assign p[i] = a[i] ^ b[i];
    end
  endgenerate

  // Every carry is a flat function of g/p/cin, no ripple between bits.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule

`default_nettype wire

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two W-bit operands one nibble per cycle through a single
// carrylookadder slice, with a start/busy/done handshake.
`default_nettype none

module wide_add_sequencer
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wide_add_sequencer_if.slave  bus
);

  localparam int W    = NIBBLE_W * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t                state;
  logic [IDXW-1:0]       idx;
  logic [W-1:0]          opa;
  logic [W-1:0]          opb;
  logic                  carry;
  logic [W-1:0]          sum_q;
  logic                  cout_q;
  logic                  ovf_q;
  logic                  busy_q;
  logic                  done_q;

  logic [NIBBLE_W-1:0]   slice_a;
  logic [NIBBLE_W-1:0]   slice_b;
  logic [NIBBLE_W-1:0]   slice_sum;
  logic                  slice_cout;

  assign slice_a = opa[NIBBLE_W*idx +: NIBBLE_W];
  assign slice_b = opb[NIBBLE_W*idx +: NIBBLE_W];

  carrylookadder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        // DONE shares IDLE's accept path so a held start chains without a gap.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opa    <= bus.a;
            opb    <= bus.b;
            carry  <= bus.cin;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          sum_q[NIBBLE_W*idx +: NIBBLE_W] <= slice_sum;
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            cout_q <= slice_cout;
            ovf_q  <= (opa[W-1] == opb[W-1]) && (slice_sum[NIBBLE_W-1] != opa[W-1]);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed, self-checking bench for wide_add_sequencer (NIBBLES=4).
`default_nettype none

module tb_wide_add_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n;
  logic busy_ok;
  logic saw_done;

  always #5 clk = ~clk;

  wide_add_sequencer_if #(.NIBBLES(4)) bus ();

  wide_add_sequencer #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until done is seen; returns cycles elapsed in n.
  task automatic wait_done(input int start_n);
    n = start_n;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    tick();
    bus.start = 1'b0;
    bus.a     = 16'hDEAD;
    bus.b     = 16'hBEEF;
    bus.cin   = ~cin;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(1);
    check({tag, "_latency"}, 32'(n), 32'd5);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.cin   = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum),  32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    run_add("simple",  16'h0001, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0);
    run_add("chain0",  16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_add("chain1",  16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0);
    run_add("wrap",    16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_add("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_add("mixed",   16'hA5C3, 16'h1B2F, 1'b1, 16'hC0F3, 1'b0, 1'b0);

    repeat (3) tick();
    check("hold_sum",  32'(bus.sum),  32'h0000C0F3);
    check("hold_busy", 32'(bus.busy), 32'd0);

    // start pulsed during RUN must be ignored
    bus.start = 1'b1;
    bus.a     = 16'h0004;
    bus.b     = 16'h0004;
    bus.cin   = 1'b0;
    tick();
    bus.start = 1'b0;
    busy_ok   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        bus.start = 1'b1;
        bus.a     = 16'h1111;
      end
      if (i == 3) bus.start = 1'b0;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 1'b0;
      tick();
    end
    check("ignore_busy_unbroken", 32'(busy_ok), 32'd1);
    check("ignore_done", 32'(bus.done), 32'd1);
    check("ignore_sum",  32'(bus.sum),  32'h00000008);
    tick();
    check("ignore_single_done", 32'(bus.done), 32'd0);
    check("ignore_idle_busy",   32'(bus.busy), 32'd0);

    // back-to-back with start held through DONE
    bus.start = 1'b1;
    bus.a     = 16'h0003;
    bus.b     = 16'h0005;
    tick();
    bus.a     = 16'h1234;
    bus.b     = 16'h4321;
    wait_done(1);
    check("b2b_first_latency", 32'(n), 32'd5);
    check("b2b_first_sum",     32'(bus.sum), 32'h00000008);
    tick();
    bus.start = 1'b0;
    check("b2b_busy_again", 32'(bus.busy), 32'd1);
    check("b2b_sum_cleared_upper", 32'(bus.sum[15:4]), 32'd0);
    wait_done(1);
    check("b2b_second_latency", 32'(n), 32'd5);
    check("b2b_second_sum",     32'(bus.sum), 32'h00005555);
    tick();

    // reset during RUN aborts with no done
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    tick();
    bus.start = 1'b0;
    tick();
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_sum",  32'(bus.sum),  32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    check("midrst_ovf",  32'(bus.ovf),  32'd0);
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("midrst_no_activity", 32'(saw_done), 32'd0);
    run_add("after_rst", 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide adder that streams two `4*NIBBLES`-bit operands, one nibble per cycle, through a single instance of the team's 4-bit carry-lookahead adder slice `carrylookadder`. It sits directly upstream of that slice: it drives the slice's `a`, `b` and `cin` inputs and consumes its `sum` and `cout`. It registers the carry between nibbles and assembles the full-width result. A start/busy/done handshake connects it to the controlling logic.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width W = 4*NIBBLES. Legal range 2..16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a new addition; sampled only when not busy.
- `a`  in  W  operand A; captured on an accepted start.
- `b`  in  W  operand B; captured on an accepted start.
- `cin`  in  1  carry-in to nibble 0; captured on an accepted start.
- `busy`  out  1  high while nibbles are being processed.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `sum`  out  W  result; held stable from `done` until the next accepted start.
- `cout`  out  1  carry out of the top nibble.
- `ovf`  out  1  two's-complement overflow of the W-bit add.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: one nibble per cycle.
  - DONE: one cycle, result valid.
- IDLE, `start`=1: capture `a`, `b` and `cin` into operand registers and the carry register. Clear the index to 0 and go to RUN.
- RUN, every cycle:
  - Drive nibble[idx] of A and B plus the carry register into the slice.
  - Write the slice `sum` into `sum[4*idx+3:4*idx]` and load `cout` into the carry register.
  - Increment idx.
  - When idx = NIBBLES-1, go to DONE on this edge instead.
- Final values, loaded at the RUN→DONE edge:
  - `cout` takes the final carry.
  - `ovf` = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]).
- DONE: `done`=1 for exactly one cycle.
  - With `start`=1, capture new operands and go straight to RUN.
  - Otherwise go to IDLE.
- `start` in RUN is ignored. No queuing and no error flag.
- `sum`, `cout` and `ovf` hold their last values in IDLE.
- On a new accepted start, `sum`, `cout` and `ovf` are cleared to 0.
- Arithmetic is unsigned modulo 2^W plus the carry-out. `ovf` applies only to the signed interpretation.
- Operand inputs may change freely after the start cycle. Only the captured copies are used.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, state IDLE, idx=0, carry register 0.
- Latency: start is accepted at edge T. Nibbles are written at edges T+1 .. T+NIBBLES. `done` is high in the cycle after edge T+NIBBLES, i.e. NIBBLES+1 cycles after the start sample.
- `busy` rises the cycle after an accepted start and stays high through the last RUN cycle. It is 0 during DONE.
- Back-to-back: `start` held high continuously gives one result every NIBBLES+1 cycles.
- Reset mid-operation: `rst` wins over everything. The operation is aborted, no `done` is produced, and all outputs return to their reset values on the next edge.
- `start` asserted in the same cycle as `rst` is ignored.

## Structure
- Shared package `adder_pkg`:
  - state enum {IDLE, RUN, DONE}
  - constant `NIBBLE_W` = 4
- Sub-module: instantiate the existing `carrylookadder` once. Do not duplicate the lookahead logic.
- idx width is $clog2(NIBBLES). Operand and result registers are W bits.

## Test plan
All scenarios use NIBBLES=4.
- **Simple add:** A=0x0001, B=0x0004, cin=0 → `sum`=0x0005, `cout`=0, `ovf`=0, `done` exactly 5 cycles after start.
- **Carry chain:** A=0x0FFF, B=0x0001, cin=0 → `sum`=0x1000. Same operands with cin=1 → `sum`=0x1001. Carry must cross three nibbles.
- **Wrap-around:**
  - A=0xFFFF, B=0x0000, cin=1 → `sum`=0x0000, `cout`=1, `ovf`=0.
  - A=0x7FFF, B=0x0001 → `sum`=0x8000, `ovf`=1, `cout`=0.
- **Start during RUN:** start A=0x0004, B=0x0004, then pulse `start` with A=0x1111 two cycles later → single `done` with `sum`=0x0008; `busy` unbroken.
- **Back-to-back via DONE:** hold `start` high with new operands A=0x1234, B=0x4321 → second `done` 5 cycles after the first, `sum`=0x5555.
- **Reset mid-RUN:** assert `rst` at cycle 2 of RUN → all outputs 0 next cycle, no `done` pulse; a following start works normally.
